// File: rtl/lock_attempt_ctrl.sv
// Attempt arbiter for the digital lock: counts failed codes, times the lockout, latches the alarm.
// Optional LOCK_BACKOFF_EN: lockout length doubles with each consecutive lockout (saturating).
module lock_attempt_ctrl #(
    parameter int MAX_TRIES      = 3,
    parameter int TRY_W          = 2,
    parameter int LOCKOUT_SEC    = 30,
    parameter int CNT_W          = 6,
    parameter int ALARM_LOCKOUTS = 2,
    parameter int STRK_W         = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sec_tick,
    input  logic             chk_valid,
    input  logic             chk_match,
    output logic             chk_ready,
    input  logic             admin_clr,
    output logic             unlock_pulse,
    output logic             fail_pulse,
    output logic             lockout,
    output logic             alarm,
    output logic [CNT_W-1:0] lock_remain,
    output logic [TRY_W-1:0] tries_left
);

    typedef enum logic [1:0] {
        READY   = 2'd0,
        LOCKOUT = 2'd1,
        ALARM   = 2'd2
    } state_t;

    localparam logic [TRY_W-1:0] TRIES_FULL = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0] TRIES_ONE  = TRY_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t            state;
    logic [STRK_W-1:0] streak;
    logic [STRK_W-1:0] streak_inc;
    logic [CNT_W-1:0]  load_value;
    logic              accept;
    logic              goes_alarm;

    assign chk_ready  = (state == READY) && !admin_clr;
    assign accept     = chk_valid && chk_ready;
    assign streak_inc = (streak == '1) ? streak : streak + 1'b1;
    assign goes_alarm = 32'(streak_inc) >= 32'(ALARM_LOCKOUTS);

`ifdef LOCK_BACKOFF_EN
    localparam longint CNT_CAP = (longint'(1) << CNT_W) - 1;

    // LOCKOUT_SEC doubled (streak-1) times, clamped at each step so it cannot overflow.
    function automatic logic [CNT_W-1:0] backoff_load(input logic [STRK_W-1:0] s);
        longint v;
        v = longint'(LOCKOUT_SEC);
        if (v > CNT_CAP) v = CNT_CAP;
        for (int i = 1; i < (1 << STRK_W); i++) begin
            if (i < int'(s)) begin
                v = v * 2;
                if (v > CNT_CAP) v = CNT_CAP;
            end
        end
        return CNT_W'(v);
    endfunction

    assign load_value = backoff_load(streak_inc);
`else
    assign load_value = CNT_W'(LOCKOUT_SEC);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= READY;
            tries_left   <= TRIES_FULL;
            lock_remain  <= '0;
            streak       <= '0;
            unlock_pulse <= 1'b0;
            fail_pulse   <= 1'b0;
            lockout      <= 1'b0;
            alarm        <= 1'b0;
        end else begin
            unlock_pulse <= 1'b0;
            fail_pulse   <= 1'b0;
            // Supervisor clear wins over everything, including an attempt in the same cycle.
            if (admin_clr) begin
                state       <= READY;
                tries_left  <= TRIES_FULL;
                lock_remain <= '0;
                streak      <= '0;
                lockout     <= 1'b0;
                alarm       <= 1'b0;
            end else begin
                unique case (state)
                    READY: begin
                        if (accept && chk_match) begin
                            unlock_pulse <= 1'b1;
                            tries_left   <= TRIES_FULL;
                            streak       <= '0;
                        end else if (accept) begin
                            fail_pulse <= 1'b1;
                            if (tries_left > TRIES_ONE) begin
                                tries_left <= tries_left - 1'b1;
                            end else begin
                                tries_left <= '0;
                                streak     <= streak_inc;
                                if (goes_alarm) begin
                                    state       <= ALARM;
                                    alarm       <= 1'b1;
                                    lock_remain <= '0;
                                end else begin
                                    state       <= LOCKOUT;
                                    lockout     <= 1'b1;
                                    lock_remain <= load_value;
                                end
                            end
                        end
                    end
                    LOCKOUT: begin
                        if (sec_tick) begin
                            if (lock_remain <= CNT_ONE) begin
                                lock_remain <= '0;
                                tries_left  <= TRIES_FULL;
                                state       <= READY;
                                lockout     <= 1'b0;
                            end else begin
                                lock_remain <= lock_remain - 1'b1;
                            end
                        end
                    end
                    ALARM: begin
                        lock_remain <= '0;
                        tries_left  <= '0;
                    end
                    default: begin
                        state       <= READY;
                        tries_left  <= TRIES_FULL;
                        lock_remain <= '0;
                        lockout     <= 1'b0;
                        alarm       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// Self-checking bench for lock_attempt_ctrl: directed scenarios plus random traffic
// compared against an integer-level model of the attempt/lockout/alarm rules.
module tb_lock_attempt_ctrl;

    localparam int MAX_TRIES   = 3;
    localparam int TRY_W       = 2;
    localparam int LOCKOUT_SEC = 30;
    localparam int CNT_W       = 6;
    localparam int STRK_W      = 2;
`ifdef LOCK_BACKOFF_EN
    localparam int ALARM_LOCKOUTS = 3;
`else
    localparam int ALARM_LOCKOUTS = 2;
`endif

    localparam int M_READY   = 0;
    localparam int M_LOCKOUT = 1;
    localparam int M_ALARM   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             sec_tick;
    logic             chk_valid;
    logic             chk_match;
    logic             chk_ready;
    logic             admin_clr;
    logic             unlock_pulse;
    logic             fail_pulse;
    logic             lockout;
    logic             alarm;
    logic [CNT_W-1:0] lock_remain;
    logic [TRY_W-1:0] tries_left;

    int checks   = 0;
    int failures = 0;

    int m_state;
    int m_tries;
    int m_remain;
    int m_streak;
    int m_unlock;
    int m_fail;

    lock_attempt_ctrl #(
        .MAX_TRIES     (MAX_TRIES),
        .TRY_W         (TRY_W),
        .LOCKOUT_SEC   (LOCKOUT_SEC),
        .CNT_W         (CNT_W),
        .ALARM_LOCKOUTS(ALARM_LOCKOUTS),
        .STRK_W        (STRK_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sec_tick    (sec_tick),
        .chk_valid   (chk_valid),
        .chk_match   (chk_match),
        .chk_ready   (chk_ready),
        .admin_clr   (admin_clr),
        .unlock_pulse(unlock_pulse),
        .fail_pulse  (fail_pulse),
        .lockout     (lockout),
        .alarm       (alarm),
        .lock_remain (lock_remain),
        .tries_left  (tries_left)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int lockout_length(input int s);
        longint v;
        v = LOCKOUT_SEC;
`ifdef LOCK_BACKOFF_EN
        for (int i = 1; i < s; i++) v = v * 2;
`endif
        if (v > (1 << CNT_W) - 1) v = (1 << CNT_W) - 1;
        return int'(v);
    endfunction

    task automatic model_reset();
        m_state  = M_READY;
        m_tries  = MAX_TRIES;
        m_remain = 0;
        m_streak = 0;
        m_unlock = 0;
        m_fail   = 0;
    endtask

    task automatic model_step(input logic v, input logic m, input logic t, input logic c);
        m_unlock = 0;
        m_fail   = 0;
        if (c) begin
            model_reset();
        end else if (m_state == M_READY) begin
            if (v && m) begin
                m_unlock = 1;
                m_tries  = MAX_TRIES;
                m_streak = 0;
            end else if (v) begin
                m_fail = 1;
                if (m_tries > 1) begin
                    m_tries--;
                end else begin
                    m_tries  = 0;
                    m_streak = (m_streak + 1 > (1 << STRK_W) - 1) ? m_streak : m_streak + 1;
                    if (m_streak >= ALARM_LOCKOUTS) begin
                        m_state  = M_ALARM;
                        m_remain = 0;
                    end else begin
                        m_state  = M_LOCKOUT;
                        m_remain = lockout_length(m_streak);
                    end
                end
            end
        end else if (m_state == M_LOCKOUT) begin
            if (t) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_tries = MAX_TRIES;
                    m_state = M_READY;
                end
            end
        end
    endtask

    task automatic check_all(input string phase);
        checkOutput({phase, ":unlock_pulse"}, int'(unlock_pulse), m_unlock);
        checkOutput({phase, ":fail_pulse"}, int'(fail_pulse), m_fail);
        checkOutput({phase, ":lockout"}, int'(lockout), int'(m_state == M_LOCKOUT));
        checkOutput({phase, ":alarm"}, int'(alarm), int'(m_state == M_ALARM));
        checkOutput({phase, ":lock_remain"}, int'(lock_remain), m_remain);
        checkOutput({phase, ":tries_left"}, int'(tries_left), m_tries);
    endtask

    // Drives one clock of inputs, checks the combinational ready, then the registered outputs.
    task automatic applyStimulus(input string phase, input logic v, input logic m,
                                 input logic t, input logic c);
        chk_valid = v;
        chk_match = m;
        sec_tick  = t;
        admin_clr = c;
        #1;
        checkOutput({phase, ":chk_ready"}, int'(chk_ready), int'(m_state == M_READY && !c));
        model_step(v, m, t, c);
        @(posedge clk);
        #1;
        check_all(phase);
    endtask

    task automatic fail_round(input string phase);
        for (int i = 0; i < MAX_TRIES; i++) applyStimulus(phase, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expire_lockout(input string phase);
        for (int i = 0; i < 300 && m_state == M_LOCKOUT; i++)
            applyStimulus(phase, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b1;
        sec_tick  = 1'b0;
        chk_valid = 1'b0;
        chk_match = 1'b0;
        admin_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        checkOutput("reset:chk_ready", int'(chk_ready), 1);
        rst = 1'b0;

        applyStimulus("unlock", 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("unlock:pulse_high", int'(unlock_pulse), 1);
        applyStimulus("unlock_end", 1'b0, 1'b0, 1'b0, 1'b0);

        fail_round("three_fails");
        checkOutput("three_fails:load", int'(lock_remain), 30);
        for (int i = 0; i < 18; i++) applyStimulus("count_down", 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("count_down:at12", int'(lock_remain), 12);
        for (int i = 0; i < 5; i++) applyStimulus("locked_attempt", 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("locked_attempt:held12", int'(lock_remain), 12);
        expire_lockout("expire");
        checkOutput("expire:tries", int'(tries_left), MAX_TRIES);
        applyStimulus("after_expire", 1'b0, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 4 && m_state != M_ALARM; r++) begin
            fail_round("escalate");
            if (m_state == M_LOCKOUT && m_streak == 2)
                checkOutput("escalate:second_load", int'(lock_remain), lockout_length(2));
            expire_lockout("escalate_expire");
        end
        checkOutput("escalate:alarm", int'(alarm), 1);
        applyStimulus("alarm_hold", 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus("admin_clr", 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("admin_clr:alarm_off", int'(alarm), 0);

        applyStimulus("clr_race", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("clr_race", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("clr_race_same", 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_race:tries", int'(tries_left), MAX_TRIES);

        fail_round("async_rst");
        for (int i = 0; i < 13; i++) applyStimulus("async_rst", 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("async_rst:at17", int'(lock_remain), 17);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst_now");
        #3;
        rst = 1'b0;
        applyStimulus("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            applyStimulus("random",
                          logic'($urandom_range(0, 99) < 50),
                          logic'($urandom_range(0, 99) < 20),
                          logic'($urandom_range(0, 99) < 35),
                          logic'($urandom_range(0, 99) < 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
